// File: rtl/mem_port_arbiter.sv
// Shares one line-wide fixed-latency memory port between the I-cache and D-cache fill engines.
// Round-robin on conflict, no preemption, one-cycle done pulse per completed access.
module mem_port_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_done,
  output logic [LINE_WORDS*WORD_SIZE-1:0] i_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] d_wdata,
  output logic                            d_done,
  output logic [LINE_WORDS*WORD_SIZE-1:0] d_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
  output logic                            busy,
  output logic                            both_wait
);

  localparam int LINE_W = LINE_WORDS * WORD_SIZE;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [LINE_W-1:0]    wdata_q, wdata_d;
  logic [LINE_W-1:0]    i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]    d_rdata_q, d_rdata_d;
  logic                 pick_d;

  // On a conflict the side that was not granted last wins; last_grant resets to I so D wins first.
  assign pick_d = d_req & (~i_req | ~last_grant_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          cnt_d        = CNT_INIT;
          last_grant_d = pick_d;
          if (pick_d) begin
            state_d = BUSY_D;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            state_d = BUSY_I;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end

      BUSY_I: begin
        mem_read  = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) begin
          i_rdata_d = mem_rdata;
          state_d   = DONE_I;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      BUSY_D: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) begin
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = DONE_D;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE_I:  state_d = IDLE;
      DONE_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_done    = (state_q == DONE_I);
  assign d_done    = (state_q == DONE_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign both_wait = i_req & d_req & (state_q != DONE_I) & (state_q != DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline reference model, directed scenarios,
// randomized requesters with occasional resets, and a LATENCY=1 instance.
module tb_mem_port_arbiter;

  localparam int W    = 16;
  localparam int LW   = 4;
  localparam int LAT  = 4;
  localparam int LINE = W * LW;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, i_done, d_req, d_we, d_done;
  logic            mem_read, mem_write, busy, both_wait;
  logic [W-1:0]    i_addr, d_addr, mem_addr;
  logic [LINE-1:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  logic            reset1, i_req1, i_done1, d_done1, mem_read1, mem_write1, busy1, both_wait1;
  logic [W-1:0]    i_addr1, mem_addr1;
  logic [LINE-1:0] i_rdata1, d_rdata1, mem_wdata1, mem_rdata1;

  logic            fixed_en;
  logic [LINE-1:0] fixed_rdata;

  int tests = 0;
  int fails = 0;

  // Reference model: owner 0=none 1=I 2=D, age = cycles since grant (1..LAT busy, LAT+1 done).
  int              owner, age;
  logic            lg;
  logic [W-1:0]    m_addr;
  logic            m_we;
  logic [LINE-1:0] m_wdata, exp_ird, exp_drd;

  int   cyc = 0;
  logic i_done_s, d_done_s, bw_seen, rand_mode;
  int   i_done_cnt, d_done_cnt, i_done_cyc, d_done_cyc, rd_cnt, wr_cnt;
  int   c0, c1;

  always #5 clk = ~clk;

  function automatic logic [LINE-1:0] memf(input logic [W-1:0] a);
    return {a ^ 16'hA5A5, a + 16'd7, ~a, {a[7:0], a[15:8]}};
  endfunction

  function automatic logic [LINE-1:0] rd(input logic [W-1:0] a);
    return fixed_en ? fixed_rdata : memf(a);
  endfunction

  assign mem_rdata  = fixed_en ? fixed_rdata : memf(mem_addr);
  assign mem_rdata1 = memf(mem_addr1);

  mem_port_arbiter #(.WORD_SIZE(W), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .both_wait(both_wait)
  );

  mem_port_arbiter #(.WORD_SIZE(W), .LINE_WORDS(LW), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1),
    .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1), .i_rdata(i_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_done(d_done1), .d_rdata(d_rdata1),
    .mem_read(mem_read1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1), .both_wait(both_wait1)
  );

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkv(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner   = 0;
    age     = 0;
    lg      = 1'b0;
    m_addr  = '0;
    m_we    = 1'b0;
    m_wdata = '0;
    exp_ird = '0;
    exp_drd = '0;
  endtask

  task automatic check_cycle();
    logic inb, dn, wr_e, rd_e;
    inb  = (owner != 0) && (age <= LAT);
    dn   = (owner != 0) && (age == LAT + 1);
    wr_e = inb && (owner == 2) && m_we;
    rd_e = inb && !wr_e;
    chkb("busy", busy, owner != 0);
    chkb("mem_read", mem_read, rd_e);
    chkb("mem_write", mem_write, wr_e);
    chkb("i_done", i_done, dn && (owner == 1));
    chkb("d_done", d_done, dn && (owner == 2));
    chkb("both_wait", both_wait, i_req && d_req && !dn);
    chkv("i_rdata", i_rdata, exp_ird);
    chkv("d_rdata", d_rdata, exp_drd);
    if (inb) chkv("mem_addr", LINE'(mem_addr), LINE'(m_addr));
    if (wr_e) chkv("mem_wdata", mem_wdata, m_wdata);
  endtask

  task automatic advance();
    logic win_d;
    if (reset) return;
    if (owner == 0) begin
      if (i_req || d_req) begin
        win_d = (i_req && d_req) ? (lg == 1'b0) : d_req;
        if (win_d) begin
          owner = 2; lg = 1'b1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
        end else begin
          owner = 1; lg = 1'b0; m_addr = i_addr; m_we = 1'b0;
        end
        age = 1;
      end
    end else if (age == LAT + 1) begin
      owner = 0;
    end else begin
      if (age == LAT) begin
        if (owner == 1) exp_ird = rd(m_addr);
        else if (!m_we) exp_drd = rd(m_addr);
      end
      age++;
    end
  endtask

  task automatic rand_inputs();
    if (reset) begin
      reset = 1'b0;
      return;
    end
    if ($urandom_range(0, 249) == 0) begin
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
      model_reset();
      return;
    end
    if (!i_req) i_req = ($urandom_range(0, 2) == 0);
    if (i_req && $urandom_range(0, 1) == 0) i_addr = W'($urandom);
    if (!d_req) d_req = ($urandom_range(0, 2) == 0);
    if (d_req && $urandom_range(0, 1) == 0) begin
      d_addr  = W'($urandom);
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = {$urandom, $urandom};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    i_done_s = i_done;
    d_done_s = d_done;
    if (i_done) begin i_done_cnt++; i_done_cyc = cyc; end
    if (d_done) begin d_done_cnt++; d_done_cyc = cyc; end
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (both_wait) bw_seen = 1'b1;
    advance();
    @(posedge clk);
    #1;
    cyc++;
    if (i_done_s) i_req = 1'b0;
    if (d_done_s) d_req = 1'b0;
    if (rand_mode) rand_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    i_done_cnt = 0; d_done_cnt = 0; i_done_cyc = -1; d_done_cyc = -1;
    rd_cnt = 0; wr_cnt = 0; bw_seen = 1'b0;
  endtask

  task automatic check_reset_zero(input string tag);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_i_done"}, i_done, 1'b0);
    chkb({tag, "_d_done"}, d_done, 1'b0);
    chkb({tag, "_mem_read"}, mem_read, 1'b0);
    chkb({tag, "_mem_write"}, mem_write, 1'b0);
    chkb({tag, "_both_wait"}, both_wait, 1'b0);
    chkv({tag, "_mem_addr"}, LINE'(mem_addr), '0);
    chkv({tag, "_mem_wdata"}, mem_wdata, '0);
    chkv({tag, "_i_rdata"}, i_rdata, '0);
    chkv({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    model_reset();
    tick();
    check_reset_zero("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1; rand_mode = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req1 = 1'b0; i_addr1 = '0;
    fixed_en = 1'b0; fixed_rdata = '0;
    model_reset();
    clr();
    tick();
    check_reset_zero("por");
    chkb("l1_por_busy", busy1, 1'b0);
    chkb("l1_por_done", i_done1 | d_done1, 1'b0);
    chkb("l1_por_cmd", mem_read1 | mem_write1 | both_wait1, 1'b0);
    chkv("l1_por_addr", LINE'(mem_addr1), '0);
    chkv("l1_por_wdata", mem_wdata1, '0);
    chkv("l1_por_rdata", i_rdata1 | d_rdata1, '0);
    reset = 1'b0; reset1 = 1'b0;

    // Single I read with a fixed memory line.
    fixed_en = 1'b1; fixed_rdata = 64'h1111_2222_3333_4444;
    clr(); c0 = cyc; i_req = 1'b1; i_addr = 16'h0040;
    run(8);
    chki("t1_done_count", i_done_cnt, 1);
    chki("t1_done_latency", i_done_cyc - c0, LAT + 1);
    chki("t1_read_cycles", rd_cnt, LAT);
    chki("t1_d_done_count", d_done_cnt, 0);
    chkv("t1_i_rdata", i_rdata, 64'h1111_2222_3333_4444);
    fixed_en = 1'b0;

    // First conflict after reset goes to D.
    do_reset();
    clr(); c0 = cyc;
    i_req = 1'b1; i_addr = 16'h0200; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    run(14);
    chki("c1_d_done_at", d_done_cyc - c0, LAT + 1);
    chki("c1_i_done_at", i_done_cyc - c0, 2 * LAT + 3);
    chkb("c1_both_wait_seen", bw_seen, 1'b1);
    chkv("c1_d_rdata", d_rdata, memf(16'h0300));
    chkv("c1_i_rdata", i_rdata, memf(16'h0200));

    // D write-back leaves d_rdata alone.
    clr();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    run(8);
    chki("wb_write_cycles", wr_cnt, LAT);
    chki("wb_read_cycles", rd_cnt, 0);
    chki("wb_done_count", d_done_cnt, 1);
    chkv("wb_d_rdata_kept", d_rdata, memf(16'h0300));
    d_we = 1'b0;

    // Last grant was D, so this conflict goes to I.
    clr(); c0 = cyc;
    i_req = 1'b1; i_addr = 16'h0500; d_req = 1'b1; d_addr = 16'h0600;
    run(14);
    chki("c2_i_done_at", i_done_cyc - c0, LAT + 1);
    chki("c2_d_done_at", d_done_cyc - c0, 2 * LAT + 3);

    // D arrives while I is mid-access: no preemption.
    clr(); c0 = cyc;
    i_req = 1'b1; i_addr = 16'h0700;
    run(2);
    d_req = 1'b1; d_addr = 16'h0800; c1 = cyc;
    run(14);
    chki("np_i_done_at", i_done_cyc - c0, LAT + 1);
    chki("np_d_done_from_req", d_done_cyc - c1, 2 * LAT + 3 - 2);
    chki("np_d_done_count", d_done_cnt, 1);

    // Reset during the second BUSY_D cycle abandons the access.
    clr();
    d_req = 1'b1; d_addr = 16'h0900;
    run(2);
    reset = 1'b1; d_req = 1'b0;
    model_reset();
    tick();
    check_reset_zero("mid");
    reset = 1'b0;
    run(8);
    chki("mid_no_done", d_done_cnt + i_done_cnt, 0);
    clr();
    d_req = 1'b1; d_addr = 16'h0A00;
    run(8);
    chki("mid_fresh_done", d_done_cnt, 1);
    chkv("mid_fresh_rdata", d_rdata, memf(16'h0A00));

    // Randomized requesters with occasional resets.
    rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // LATENCY=1 instance.
    i_req1 = 1'b1; i_addr1 = 16'h1234;
    @(negedge clk);
    chkb("l1_grant_read", mem_read1, 1'b0);
    chkb("l1_grant_busy", busy1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chkb("l1_busy_read", mem_read1, 1'b1);
    chkv("l1_busy_addr", LINE'(mem_addr1), LINE'(16'h1234));
    chkb("l1_busy_done", i_done1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chkb("l1_done", i_done1, 1'b1);
    chkb("l1_done_read", mem_read1, 1'b0);
    chkv("l1_rdata", i_rdata1, memf(16'h1234));
    @(posedge clk); #1;
    i_req1 = 1'b0;
    @(negedge clk);
    chkb("l1_after_done", i_done1, 1'b0);
    chkb("l1_after_busy", busy1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
